// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with a fixed refractory window.
//   clk         : single clock, rising edge
//   reset       : synchronous active-high reset
//   pre_spike   : presynaptic spike, sampled every cycle
//   weight      : unsigned synaptic weight, used with pre_spike on the same edge
//   post_spike  : registered one-cycle output spike
//   membrane    : registered membrane potential
//   refractory  : high while the neuron is in its refractory window
//   spike_count : registered saturating fire count since reset
module lif_neuron #(
  parameter logic [7:0]  THRESHOLD  = 8'd200,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter logic [7:0]  V_RESET    = 8'd0,
  parameter logic [3:0]  REFRACTORY = 4'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pre_spike,
  input  logic [7:0]  weight,
  output logic        post_spike,
  output logic [7:0]  membrane,
  output logic        refractory,
  output logic [15:0] spike_count
);

  localparam int unsigned V_W   = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned REF_W = 4;

  typedef enum logic {
    ST_INTEGRATE = 1'b0,
    ST_REFRACT   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [V_W-1:0]     v_q, v_d;
  logic               post_spike_q, post_spike_d;
  logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic [CNT_W-1:0]   spike_count_q, spike_count_d;

  logic [V_W-1:0]     leak;
  logic [V_W-1:0]     v_leaked;
  logic [V_W-1:0]     w_eff;
  logic [V_W:0]       v_sum;
  logic [V_W-1:0]     v_next;

  // Integration datapath: leak never exceeds v, so the subtraction cannot underflow.
  always_comb begin
    leak     = v_q >> LEAK_SHIFT;
    v_leaked = v_q - leak;
    w_eff    = pre_spike ? weight : '0;
    v_sum    = {1'b0, v_leaked} + {1'b0, w_eff};
    v_next   = v_sum[V_W] ? {V_W{1'b1}} : v_sum[V_W-1:0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    v_d           = v_q;
    post_spike_d  = 1'b0;
    ref_cnt_d     = ref_cnt_q;
    spike_count_d = spike_count_q;

    case (state_q)
      ST_INTEGRATE: begin
        if (v_next >= THRESHOLD) begin
          state_d       = ST_REFRACT;
          v_d           = V_RESET;
          post_spike_d  = 1'b1;
          ref_cnt_d     = REFRACTORY;
          spike_count_d = (spike_count_q == {CNT_W{1'b1}}) ? spike_count_q
                                                           : spike_count_q + CNT_W'(1);
        end else begin
          v_d = v_next;
        end
      end
      ST_REFRACT: begin
        // Inputs are ignored; the window closes after REFRACTORY cycles.
        v_d = V_RESET;
        if (ref_cnt_q <= REF_W'(1)) begin
          state_d   = ST_INTEGRATE;
          ref_cnt_d = '0;
        end else begin
          ref_cnt_d = ref_cnt_q - REF_W'(1);
        end
      end
      default: begin
        state_d = ST_INTEGRATE;
      end
    endcase
  end

  // State and output registers; reset overrides everything including a fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INTEGRATE;
      v_q           <= '0;
      post_spike_q  <= 1'b0;
      ref_cnt_q     <= '0;
      spike_count_q <= '0;
    end else begin
      state_q       <= state_d;
      v_q           <= v_d;
      post_spike_q  <= post_spike_d;
      ref_cnt_q     <= ref_cnt_d;
      spike_count_q <= spike_count_d;
    end
  end

  assign post_spike  = post_spike_q;
  assign membrane    = v_q;
  assign refractory  = (state_q == ST_REFRACT);
  assign spike_count = spike_count_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron: directed scenarios plus random traffic,
// compared against an arithmetic reference model of two neurons (threshold 200 and 255).
module tb_lif_neuron;

  logic        clk = 1'b0;
  logic        reset;
  logic        pre_spike;
  logic [7:0]  weight;

  logic        post_a, post_b;
  logic [7:0]  mem_a, mem_b;
  logic        ref_a, ref_b;
  logic [15:0] cnt_a, cnt_b;

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = default neuron, 1 = threshold 255 neuron.
  int m_v[2];
  int m_post[2];
  int m_ref_left[2];
  int m_cnt[2];
  int m_thr[2];

  always #5 clk = ~clk;

  lif_neuron dut_a (
    .clk(clk), .reset(reset), .pre_spike(pre_spike), .weight(weight),
    .post_spike(post_a), .membrane(mem_a), .refractory(ref_a), .spike_count(cnt_a)
  );

  lif_neuron #(.THRESHOLD(8'd255)) dut_b (
    .clk(clk), .reset(reset), .pre_spike(pre_spike), .weight(weight),
    .post_spike(post_b), .membrane(mem_b), .refractory(ref_b), .spike_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the behavioural neuron.
  task automatic model_step(input int i, input bit p, input int w, input bit rst);
    int nx;
    if (rst) begin
      m_v[i] = 0; m_post[i] = 0; m_ref_left[i] = 0; m_cnt[i] = 0;
    end else if (m_ref_left[i] > 0) begin
      m_ref_left[i] = m_ref_left[i] - 1;
      m_post[i] = 0;
      m_v[i] = 0;
    end else begin
      nx = m_v[i] - (m_v[i] / 8) + (p ? w : 0);
      if (nx > 255) nx = 255;
      if (nx >= m_thr[i]) begin
        m_post[i] = 1;
        m_v[i] = 0;
        m_ref_left[i] = 4;
        if (m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
      end else begin
        m_v[i] = nx;
        m_post[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("a_post",  16'(post_a), 16'(m_post[0]));
    chk("a_mem",   16'(mem_a),  16'(m_v[0]));
    chk("a_refr",  16'(ref_a),  16'(m_ref_left[0] > 0));
    chk("a_count", cnt_a,       16'(m_cnt[0]));
    chk("b_post",  16'(post_b), 16'(m_post[1]));
    chk("b_mem",   16'(mem_b),  16'(m_v[1]));
    chk("b_refr",  16'(ref_b),  16'(m_ref_left[1] > 0));
    chk("b_count", cnt_b,       16'(m_cnt[1]));
  endtask

  // Drive at the falling edge, clock once, then compare at the next falling edge.
  task automatic step(input bit p, input int w, input bit rst = 1'b0);
    pre_spike = p;
    weight    = 8'(w);
    reset     = rst;
    @(posedge clk);
    model_step(0, p, w, rst);
    model_step(1, p, w, rst);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int leak_exp[5];
    leak_exp[0] = 100; leak_exp[1] = 88; leak_exp[2] = 77; leak_exp[3] = 68; leak_exp[4] = 60;
    m_thr[0] = 200;
    m_thr[1] = 255;
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_post[i] = 0; m_ref_left[i] = 0; m_cnt[i] = 0;
    end
    reset = 1'b1; pre_spike = 1'b0; weight = 8'd0;
    @(negedge clk);

    // Reset held two cycles.
    step(0, 0, 1);
    step(0, 0, 1);
    chk("reset_mem",   16'(mem_a), 16'd0);
    chk("reset_post",  16'(post_a), 16'd0);
    chk("reset_refr",  16'(ref_a), 16'd0);
    chk("reset_count", cnt_a, 16'd0);

    // Leak sequence after one input of 100.
    step(1, 100);
    chk("leak_0", 16'(mem_a), 16'(leak_exp[0]));
    for (int k = 1; k < 5; k++) begin
      step(0, 0);
      chk("leak_k", 16'(mem_a), 16'(leak_exp[k]));
      chk("leak_nopost", 16'(post_a), 16'd0);
    end
    // weight 0 with a spike is just leak.
    step(1, 0);
    chk("zero_weight", 16'(mem_a), 16'd53);

    // Fire, refractory window, then fire again on the first free cycle.
    step(0, 0, 1);
    step(1, 110);
    chk("fire_pre", 16'(mem_a), 16'd110);
    step(1, 110);
    chk("fire_post", 16'(post_a), 16'd1);
    chk("fire_mem",  16'(mem_a), 16'd0);
    chk("fire_cnt",  cnt_a, 16'd1);
    chk("fire_refr", 16'(ref_a), 16'd1);
    for (int k = 0; k < 3; k++) begin
      step(1, 255);
      chk("refr_hold", 16'(ref_a), 16'd1);
      chk("refr_nopost", 16'(post_a), 16'd0);
      chk("refr_mem", 16'(mem_a), 16'd0);
    end
    step(1, 255);
    chk("refr_end", 16'(ref_a), 16'd0);
    step(1, 255);
    chk("refire_post", 16'(post_a), 16'd1);
    chk("refire_cnt", cnt_a, 16'd2);

    // Saturation at threshold 255 (neuron b).
    step(0, 0, 1);
    step(1, 240);
    chk("sat_pre", 16'(mem_b), 16'd240);
    step(1, 255);
    chk("sat_post", 16'(post_b), 16'd1);
    chk("sat_mem", 16'(mem_b), 16'd0);

    // Reset during the second refractory cycle.
    step(0, 0, 1);
    step(1, 110);
    step(1, 110);
    step(0, 0);
    step(0, 0, 1);
    chk("midrst_refr", 16'(ref_a), 16'd0);
    chk("midrst_cnt", cnt_a, 16'd0);
    step(1, 50);
    chk("midrst_int", 16'(mem_a), 16'd50);

    // Counter saturation from a preloaded value.
    step(0, 0, 1);
    force dut_a.spike_count_q = 16'hFFFE;
    #1;
    release dut_a.spike_count_q;
    m_cnt[0] = 65534;
    step(1, 255);
    chk("cnt_sat1", cnt_a, 16'hFFFF);
    for (int k = 0; k < 4; k++) step(0, 0);
    step(1, 255);
    chk("cnt_sat_post", 16'(post_a), 16'd1);
    chk("cnt_sat2", cnt_a, 16'hFFFF);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
